// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mdu_state_e;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit_iter_core.sv
// One iteration of the shift-add multiplier and the restoring divider.
// Purely combinational; the FSM in mul_div_unit registers the results.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   mcand_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o,
  input  logic [XLEN-1:0]   divisor_i,
  input  logic [XLEN-1:0]   quo_i,
  input  logic [XLEN-1:0]   rem_i,
  output logic [XLEN-1:0]   quo_o,
  output logic [XLEN-1:0]   rem_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // Multiplier: acc holds {partial_high, remaining multiplier bits}; add the
  // multiplicand into the high half when the LSB is set, then shift right.
  // Divider: shift the next dividend bit into the partial remainder and
  // subtract the divisor when it fits (borrow lands in diff[XLEN]).
  always_comb begin
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, mcand_i} : '0);
    acc_o   = {add_sum, acc_i[XLEN-1:1]};

    trial = {rem_i, quo_i[XLEN-1]};
    diff  = trial - {1'b0, divisor_i};
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = trial[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M execute-stage unit: multiplies via shift-add and divides
// via restoring division on operand magnitudes, fixing signs at the end.
// Responder on the EX start/stall handshake; honours the branch-flush kill.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  mdu_state_e        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              neg_prod_q, neg_prod_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;

  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   quo_step, rem_step;

  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   quo_fin, rem_fin, final_res;

  mdu_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .mcand_i   (mcand_q),
    .acc_i     (acc_q),
    .acc_o     (acc_step),
    .divisor_i (divisor_q),
    .quo_i     (quo_q),
    .rem_i     (rem_q),
    .quo_o     (quo_step),
    .rem_o     (rem_step)
  );

  // Decode the incoming request: magnitudes, signs and 1-cycle special cases.
  always_comb begin
    accept   = (state_q == IDLE) && start_i && !flush_i;
    sgn_a    = is_signed_a(funct3_i) && op_a_i[XLEN-1];
    sgn_b    = is_signed_b(funct3_i) && op_b_i[XLEN-1];
    mag_a    = sgn_a ? -op_a_i : op_a_i;
    mag_b    = sgn_b ? -op_b_i : op_b_i;
    div_zero = is_div(funct3_i) && (op_b_i == '0);
    div_ovf  = is_div(funct3_i) && is_signed_b(funct3_i) &&
               (op_a_i == INT_MIN) && (op_b_i == '1);
    special  = div_zero || div_ovf;
  end

  // Apply sign fix-ups and pick the architectural result.
  always_comb begin
    prod_fin = neg_prod_q ? -acc_q : acc_q;
    quo_fin  = neg_quo_q ? -quo_q : quo_q;
    rem_fin  = neg_rem_q ? -rem_q : rem_q;
    case (f3_q)
      F3_MUL:                      final_res = prod_fin[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fin[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             final_res = quo_fin;
      default:                     final_res = rem_fin;
    endcase
  end

  // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    mcand_d    = mcand_q;
    divisor_d  = divisor_q;
    acc_d      = acc_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    neg_prod_d = neg_prod_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d      = funct3_i;
          mcand_d   = mag_a;
          divisor_d = mag_b;
          cnt_d     = '0;
          if (special) begin
            // Special results are parked pre-signed in quo/rem so the
            // common result mux serves both paths.
            quo_d      = div_zero ? DIV_BY_ZERO_Q : INT_MIN;
            rem_d      = div_zero ? op_a_i : '0;
            acc_d      = '0;
            neg_prod_d = 1'b0;
            neg_quo_d  = 1'b0;
            neg_rem_d  = 1'b0;
            state_d    = DONE;
          end else begin
            acc_d      = {{XLEN{1'b0}}, mag_b};
            quo_d      = mag_a;
            rem_d      = '0;
            neg_prod_d = sgn_a ^ sgn_b;
            neg_quo_d  = sgn_a ^ sgn_b;
            neg_rem_d  = sgn_a;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          if (is_div(f3_q)) begin
            quo_d = quo_step;
            rem_d = rem_step;
          end else begin
            acc_d = acc_step;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs; result is exposed combinationally during DONE and
  // captured so it holds afterwards. A flush in DONE leaves it untouched.
  always_comb begin
    stall_o  = accept || (state_q == CALC);
    busy_o   = (state_q == CALC);
    done_o   = (state_q == DONE) && !flush_i;
    result_d = done_o ? final_res : result_q;
    result_o = result_d;
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      mcand_q    <= '0;
      divisor_q  <= '0;
      acc_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      mcand_q    <= mcand_d;
      divisor_q  <= divisor_d;
      acc_q      <= acc_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
      neg_prod_q <= neg_prod_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized ops
// against an arithmetic reference model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(
    .XLEN(32),
    .ITER(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      F3_MUL:    begin p = ua * ub; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      F3_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      F3_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      4:       return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, hold start as EX would, scramble operands during CALC,
  // and check latency, stall behaviour, result and result hold.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp_r;
    int          exp_lat;
    int          lat;
    bit          stall_ok;
    bit          seen;
    exp_r    = ref_model(f3, a, b);
    exp_lat  = ref_latency(f3, a, b);
    lat      = 0;
    stall_ok = 1'b1;
    seen     = 1'b0;
    @(negedge clk);
    funct3_i = f3;
    op_a_i   = a;
    op_b_i   = b;
    start_i  = 1'b1;
    #1 check_eq({tag, " stall@accept"}, stall_o, 1);
    @(posedge clk);
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        if (!stall_o) stall_ok = 1'b0;
        op_a_i = $urandom;
        op_b_i = $urandom;
      end
    end
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " stall_held"}, stall_ok, 1);
    check_eq({tag, " result"}, result_o, exp_r);
    check_eq({tag, " stall@done"}, stall_o, 0);
    start_i = 1'b0;
    @(negedge clk);
    check_eq({tag, " done_pulse"}, done_o, 0);
    check_eq({tag, " result_hold"}, result_o, exp_r);
  endtask

  // Watch a window of cycles and report whether done_o ever rose.
  task automatic watch_no_done(input string tag, input logic [31:0] held);
    bit any_done;
    any_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) any_done = 1'b1;
    end
    check_eq({tag, " no_done"}, any_done, 0);
    check_eq({tag, " result_unchanged"}, result_o, held);
  endtask

  initial begin
    logic [31:0] prev;
    rst      = 1'b1;
    start_i  = 1'b0;
    flush_i  = 1'b0;
    funct3_i = '0;
    op_a_i   = '0;
    op_b_i   = '0;
    #1;
    check_eq("reset busy", busy_o, 0);
    check_eq("reset done", done_o, 0);
    check_eq("reset stall", stall_o, 0);
    check_eq("reset result", result_o, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_7xm3", F3_MUL, 32'd7, 32'hFFFF_FFFD);
    run_op("mulhu_ff", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_ff", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_ff", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_zero", F3_DIVU, 32'h1234, 32'd0);
    run_op("remu_zero", F3_REMU, 32'h1234, 32'd0);
    run_op("div_zero_neg", F3_DIV, 32'hFFFF_FFF0, 32'd0);
    run_op("div_m7_2", F3_DIV, -32'd7, 32'd2);
    run_op("rem_m7_2", F3_REM, -32'd7, 32'd2);
    run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7);
    run_op("remu_100_7", F3_REMU, 32'd100, 32'd7);

    for (int i = 0; i < 48; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    // Flush mid-CALC: unit drops to IDLE, never signals done, keeps result.
    prev = result_o;
    @(negedge clk);
    funct3_i = F3_DIVU;
    op_a_i   = 32'd1000;
    op_b_i   = 32'd3;
    start_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1 check_eq("flush busy@10", busy_o, 1);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check_eq("flush busy@11", busy_o, 0);
    check_eq("flush stall@11", stall_o, 0);
    watch_no_done("flush_calc", prev);

    // Start and flush together: not accepted.
    @(negedge clk);
    funct3_i = F3_MUL;
    op_a_i   = 32'd3;
    op_b_i   = 32'd5;
    start_i  = 1'b1;
    flush_i  = 1'b1;
    #1 check_eq("start+flush stall", stall_o, 0);
    @(negedge clk);
    check_eq("start+flush busy", busy_o, 0);
    start_i = 1'b0;
    flush_i = 1'b0;
    watch_no_done("start_flush", prev);

    // Flush during DONE of a special op: done suppressed, result kept.
    @(negedge clk);
    funct3_i = F3_DIVU;
    op_a_i   = 32'h55;
    op_b_i   = 32'd0;
    start_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    start_i = 1'b0;
    #1;
    check_eq("flush_done done", done_o, 0);
    check_eq("flush_done result", result_o, prev);
    @(negedge clk);
    flush_i = 1'b0;
    #1 check_eq("flush_done idle", busy_o, 0);
    watch_no_done("flush_done", prev);

    // Asynchronous reset in the middle of a multiply.
    run_op("mul_pre_rst", F3_MUL, 32'd1234, 32'd5678);
    @(negedge clk);
    funct3_i = F3_MUL;
    op_a_i   = 32'd9;
    op_b_i   = 32'd11;
    start_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst busy", busy_o, 0);
    check_eq("async_rst done", done_o, 0);
    check_eq("async_rst stall", stall_o, 0);
    check_eq("async_rst result", result_o, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("mul_post_rst", F3_MUL, 32'd123, 32'hFFFF_FF00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
